// File: rtl/i_mem_fill_responder_pkg.sv
// rtl/i_mem_fill_responder_pkg.sv - shared types for the IMEM fill responder
package i_mem_fill_responder_pkg;

  localparam int CL_WIDTH   = 128;
  localparam int IMEM_BEATS = CL_WIDTH / 32;

  typedef struct packed {
    logic [31:0] fill_requested_address;
    logic        fill_requested_address_valid;
  } t_cache2i_mem_req;

  typedef struct packed {
    logic [CL_WIDTH-1:0] filled_instruction;
    logic                valid;
    logic [31:0]         address;
  } t_i_mem2cache_rsp;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_READ,
    S_RSP
  } t_imem_fill_states;

endpackage

// File: rtl/i_mem_fill_responder_if.sv
// rtl/i_mem_fill_responder_if.sv - cache fill request/response and IMEM write bus
interface i_mem_fill_responder_if;
  import i_mem_fill_responder_pkg::*;

  t_cache2i_mem_req req;
  t_i_mem2cache_rsp rsp;
  logic             wr_en;
  logic [31:0]      wr_addr;
  logic [31:0]      wr_data;
  logic             busy;
  logic             req_dropped;

  modport master (
    output req, wr_en, wr_addr, wr_data,
    input  rsp, busy, req_dropped
  );

  modport slave (
    input  req, wr_en, wr_addr, wr_data,
    output rsp, busy, req_dropped
  );

endinterface

// File: rtl/i_mem_fill_responder_sram.sv
// rtl/i_mem_fill_responder_sram.sv - IMEM word array, one write port, one sync read port
module i_mem_sram #(
  parameter int DEPTH = 1024,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [31:0]   wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [31:0]   rd_data
);

  logic [31:0] mem [DEPTH];

  // Same-word write and read in one cycle returns the old word.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/i_mem_fill_responder.sv
// rtl/i_mem_fill_responder.sv - answers I-cache line fills from a local IMEM
// Optional IFU_IMEM_ADDR_CHK_EN adds addr_err and out-of-range handling.
module i_mem_fill_responder
  import i_mem_fill_responder_pkg::*;
#(
  parameter int IMEM_DEPTH   = 1024,
  parameter int FILL_LATENCY = 2
) (
  input  logic clk,
  input  logic rst_n,
`ifdef IFU_IMEM_ADDR_CHK_EN
  output logic addr_err,
`endif
  i_mem_fill_responder_if.slave bus
);

  localparam int IDX_W = $clog2(IMEM_DEPTH);
  localparam logic [3:0] LAT_LAST  = 4'(FILL_LATENCY - 1);
  localparam logic [1:0] LAST_BEAT = 2'(IMEM_BEATS - 1);
  localparam t_imem_fill_states FILL_START = (FILL_LATENCY == 0) ? S_READ : S_WAIT;

  t_imem_fill_states state_q, state_d;
  logic [31:0] act_base_q, pend_base_q, req_base, next_base;
  logic        pend_v_q, drop_q;
  logic [3:0]  wait_cnt_q;
  logic [1:0]  beat_q;
  logic [95:0] line_q;
  logic        req_v, match, new_req;
  logic        load_act, take_pend, pend_load, pend_clear, drop;
  logic        rd_en, wr_en;
  logic [31:0] rd_data;
  logic [IDX_W-1:0] rd_idx, wr_idx;

  assign req_v     = bus.req.fill_requested_address_valid;
  assign req_base  = bus.req.fill_requested_address & 32'hFFFF_FFF0;
  assign match     = ((state_q != S_IDLE) && (req_base == act_base_q)) ||
                     (pend_v_q && (req_base == pend_base_q));
  assign new_req   = req_v && !match;
  assign next_base = take_pend ? pend_base_q : req_base;

  always_comb begin
    state_d    = state_q;
    load_act   = 1'b0;
    take_pend  = 1'b0;
    pend_load  = 1'b0;
    pend_clear = 1'b0;
    drop       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (new_req) begin
          load_act = 1'b1;
          state_d  = FILL_START;
        end
      end
      S_WAIT: if (wait_cnt_q == LAT_LAST) state_d = S_READ;
      S_READ: if (beat_q == LAST_BEAT) state_d = S_RSP;
      S_RSP: begin
        // Chain straight into the next fill so no idle bubble is inserted.
        if (pend_v_q) begin
          load_act   = 1'b1;
          take_pend  = 1'b1;
          state_d    = FILL_START;
          pend_load  = new_req;
          pend_clear = !new_req;
        end else if (new_req) begin
          load_act = 1'b1;
          state_d  = FILL_START;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if ((state_q == S_WAIT || state_q == S_READ) && new_req) begin
      if (pend_v_q) drop = 1'b1;
      else          pend_load = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      act_base_q  <= '0;
      pend_base_q <= '0;
      pend_v_q    <= 1'b0;
      drop_q      <= 1'b0;
      wait_cnt_q  <= '0;
      beat_q      <= '0;
      line_q      <= '0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop;
      if (load_act) begin
        act_base_q <= next_base;
        wait_cnt_q <= '0;
        beat_q     <= '0;
      end else begin
        if (state_q == S_WAIT) wait_cnt_q <= wait_cnt_q + 4'd1;
        if (state_q == S_READ) beat_q <= beat_q + 2'd1;
      end
      // Words 0..2 shift in from the top; word 3 is taken live in S_RSP.
      if (state_q == S_READ && beat_q != 2'd0) line_q <= {rd_data, line_q[95:32]};
      if (pend_load) begin
        pend_base_q <= req_base;
        pend_v_q    <= 1'b1;
      end else if (pend_clear) begin
        pend_v_q <= 1'b0;
      end
    end
  end

  assign rd_en  = (state_q == S_READ);
  assign rd_idx = {act_base_q[IDX_W+1:4], beat_q};
  assign wr_idx = bus.wr_addr[2 +: IDX_W];

`ifdef IFU_IMEM_ADDR_CHK_EN
  logic act_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        act_err_q <= 1'b0;
    else if (load_act) act_err_q <= |next_base[31:IDX_W+2];
  end

  assign wr_en    = bus.wr_en && (bus.wr_addr[31:IDX_W+2] == '0);
  assign addr_err = (state_q == S_RSP) && act_err_q;
`else
  assign wr_en = bus.wr_en;
`endif

  always_comb begin
    bus.rsp = '0;
    if (state_q == S_RSP) begin
      bus.rsp.valid              = 1'b1;
      bus.rsp.address            = act_base_q;
      bus.rsp.filled_instruction = {rd_data, line_q};
`ifdef IFU_IMEM_ADDR_CHK_EN
      if (act_err_q) bus.rsp.filled_instruction = '0;
`endif
    end
  end

  assign bus.busy        = (state_q != S_IDLE) || pend_v_q;
  assign bus.req_dropped = drop_q;

  i_mem_sram #(
    .DEPTH(IMEM_DEPTH)
  ) u_sram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_idx),
    .wr_data (bus.wr_data),
    .rd_en   (rd_en),
    .rd_addr (rd_idx),
    .rd_data (rd_data)
  );

endmodule
